vga_dot_render: RTL and testbench
=================================

# vga_dot_render

- Downstream consumer of the bouncing-dot position generator.
- Generates 640x480 VGA timing from the system clock and draws a DOT_SIZE square at the latched dot position in 8-bit RGB.
- Produces the once-per-N-frames cursor tick (`clk_cursor`, `prev_clk_cursor`) that paces the position generator.
- Dot position is captured once per frame during vertical blanking, so the image never tears.

## Interface
- PIX_DIV, 4: clk cycles per pixel (100 MHz to 25 MHz).
- HPIXELS, 800 / VLINES, 521: total pixels per line / total lines per frame.
- HPULSE, 96 / VPULSE, 2: sync pulse widths, in pixels / lines.
- HBP, 144 / HFP, 784 / VBP, 31 / VFP, 511: active window bounds, [HBP,HFP) x [VBP,VFP).
- DOT_SIZE, 8: dot edge length in pixels.
- CURSOR_DIV, 2: frames per cursor tick; must be 2 or more.
- DOT_COLOR, 8'hE0 / BG_COLOR, 8'h00 / BORDER_COLOR, 8'h1C: RGB 3-3-2 colours.
- X_LO, 234 / X_HI, 694 / Y_LO, 111 / Y_HI, 431: playfield border coordinates.
- clk  in  1  system clock; every flop is on its rising edge.
- clr  in  1  asynchronous reset, active-low; this is fixed.
- dot_x  in  10  dot left edge, in screen counter coordinates.
- dot_y  in  10  dot top edge, in screen counter coordinates.
- hsync  out  1  horizontal sync, active-low.
- vsync  out  1  vertical sync, active-low.
- red  out  3 / green  out  3 / blue  out  2  pixel colour.
- clk_cursor  out  1  cursor tick level.
- prev_clk_cursor  out  1  `clk_cursor` delayed by one clk.

## Operation
- Pixel enable:
  - pix_cnt counts 0..PIX_DIV-1 on every clk and wraps.
  - pix_en = (pix_cnt == PIX_DIV-1), combinational.
- Counters, advanced only when pix_en is high:
  - hc counts 0..HPIXELS-1 and wraps to 0.
  - When hc wraps, vc increments; vc wraps from VLINES-1 to 0.
  - When vc wraps, frame_cnt increments modulo CURSOR_DIV.
- Dot latch:
  - On the pix_en edge where hc==HPIXELS-1 and vc==VFP-1, dx_l<=dot_x and dy_l<=dot_y.
  - This is the start of bottom blanking.
  - dot_x/dot_y may change at any other time without visible effect.
- Pixel classification, using pre-increment hc/vc:
  - active = HBP<=hc<HFP and VBP<=vc<VFP.
  - dot = dx_l<=hc<dx_l+DOT_SIZE and dy_l<=vc<dy_l+DOT_SIZE.
  - Sums are computed 11 bits wide; there is no wrap at 1023.
- Colour priority:
  - Not active gives 0, so blanking is black regardless of dot or border.
  - Otherwise dot gives DOT_COLOR, then border (see Configuration) gives BORDER_COLOR, otherwise BG_COLOR.
  - The colour maps to {red,green,blue}.
- Sync: hsync = !(hc<HPULSE); vsync = !(vc<VPULSE).
- Cursor tick:
  - clk_cursor is registered to (frame_cnt == CURSOR_DIV-1), so it is high for one whole frame out of CURSOR_DIV.
  - prev_clk_cursor <= clk_cursor on every clk.
  - A consumer testing !prev && cur therefore sees exactly one rising edge per CURSOR_DIV frames, at vc=0.
  - That is inside top blanking and after the latch.

## Timing
- Reset values while clr is low:
  - pix_cnt, hc, vc, frame_cnt = 0.
  - dx_l=(HBP+HFP)/2=464, dy_l=(VBP+VFP)/2=271.
  - hsync=1, vsync=1, rgb=0, clk_cursor=0, prev_clk_cursor=0.
- Reset mid-frame:
  - All outputs go to their reset values immediately, asynchronously.
  - Timing restarts at hc=vc=0 after release.
- hsync/vsync/rgb are registered on pix_en edges from the same hc/vc.
  - They are mutually aligned.
  - Their latency is one clk behind the counter value.
- The first pix_en edge is the 4th clk edge after clr deasserts.
- Line period is 3200 clk; hsync is low for 384 clk.
- Frame period is 1,667,200 clk; vsync is low for 6400 clk.
- A dot_x/dot_y change takes effect from the first active line of the next frame after the latch point.

## Configuration
- Macro: PLAYFIELD_BORDER_EN.
- Defined:
  - Active pixels with (hc==X_LO or hc==X_HI) and Y_LO<=vc<=Y_HI are border.
  - Active pixels with (vc==Y_LO or vc==Y_HI) and X_LO<=hc<=X_HI are border.
  - The dot overrides the border.
- Undefined: no border logic is present, and those pixels show BG_COLOR.

## Test plan
- Timing: release clr, run 2 frames -> hsync period 3200 clk, low 384 clk; vsync period 1,667,200 clk, low 6400 clk.
- Default dot: no input change -> pixels (464..471, 271..278) = 8'hE0; (463,271) and (472,278) = 8'h00.
- Latch: with dot_x=300 applied at vc=100 -> current frame draws at hc=464; next frame draws at hc=300..307.
- Blanking clip: dot_x=780 -> hc 780..783 = 8'hE0 and hc>=784 = 0; dot_y=0 -> no dot drawn.
- Cursor, CURSOR_DIV=2 -> clk_cursor high for one frame of every two; prev_clk_cursor lags by 1 clk; edge at hc=vc=0.
- Border and reset:
  - With PLAYFIELD_BORDER_EN, (234,111) = 8'h1C; without it, 8'h00.
  - clr pulsed low at vc=200 -> all outputs reset at once, and hc=vc=0 after release.

Source files
------------

// File: rtl/vga_dot_render.sv
// 640x480 VGA timing with a latched DOT_SIZE square and a once-per-CURSOR_DIV-frames cursor tick.
// Optional playfield outline is enabled by defining PLAYFIELD_BORDER_EN.
module vga_dot_render #(
  parameter int unsigned PIX_DIV    = 4,
  parameter logic [9:0]  HPIXELS    = 10'd800,
  parameter logic [9:0]  VLINES     = 10'd521,
  parameter logic [9:0]  HPULSE     = 10'd96,
  parameter logic [9:0]  VPULSE     = 10'd2,
  parameter logic [9:0]  HBP        = 10'd144,
  parameter logic [9:0]  HFP        = 10'd784,
  parameter logic [9:0]  VBP        = 10'd31,
  parameter logic [9:0]  VFP        = 10'd511,
  parameter logic [9:0]  DOT_SIZE   = 10'd8,
  parameter int unsigned CURSOR_DIV = 2,
  parameter logic [7:0]  DOT_COLOR  = 8'hE0,
  parameter logic [7:0]  BG_COLOR   = 8'h00
`ifdef PLAYFIELD_BORDER_EN
  ,
  parameter logic [7:0]  BORDER_COLOR = 8'h1C,
  parameter logic [9:0]  X_LO         = 10'd234,
  parameter logic [9:0]  X_HI         = 10'd694,
  parameter logic [9:0]  Y_LO         = 10'd111,
  parameter logic [9:0]  Y_HI         = 10'd431
`endif
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [9:0] dot_x,
  input  logic [9:0] dot_y,
  output logic       hsync,
  output logic       vsync,
  output logic [2:0] red,
  output logic [2:0] green,
  output logic [1:0] blue,
  output logic       clk_cursor,
  output logic       prev_clk_cursor
);

  localparam int PCW = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam int FCW = $clog2(CURSOR_DIV);
  localparam logic [PCW-1:0] PIX_LAST = PCW'(PIX_DIV - 1);
  localparam logic [PCW-1:0] PIX_ONE  = PCW'(1);
  localparam logic [FCW-1:0] F_LAST   = FCW'(CURSOR_DIV - 1);
  localparam logic [FCW-1:0] F_ONE    = FCW'(1);
  localparam logic [9:0]     HC_LAST  = HPIXELS - 10'd1;
  localparam logic [9:0]     VC_LAST  = VLINES - 10'd1;
  localparam logic [9:0]     VC_LATCH = VFP - 10'd1;
  // Reset dot position is the centre of the active window.
  localparam logic [10:0]    DX_SUM   = {1'b0, HBP} + {1'b0, HFP};
  localparam logic [10:0]    DY_SUM   = {1'b0, VBP} + {1'b0, VFP};
  localparam logic [9:0]     DX_RST   = DX_SUM[10:1];
  localparam logic [9:0]     DY_RST   = DY_SUM[10:1];

  logic [PCW-1:0] r_pix_cnt;
  logic [9:0]     r_hc;
  logic [9:0]     r_vc;
  logic [FCW-1:0] r_frame;
  logic [9:0]     r_dx;
  logic [9:0]     r_dy;
  logic           r_hsync;
  logic           r_vsync;
  logic [7:0]     r_rgb;
  logic           r_cursor;
  logic           r_prev_cursor;

  logic           w_pix_en;
  logic           w_h_last;
  logic           w_v_last;
  logic           w_active;
  logic           w_dot;
  logic [10:0]    w_dx_end;
  logic [10:0]    w_dy_end;
  logic [7:0]     w_color;

  assign w_pix_en = (r_pix_cnt == PIX_LAST);
  assign w_h_last = (r_hc == HC_LAST);
  assign w_v_last = (r_vc == VC_LAST);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_pix_cnt <= '0;
    end else if (w_pix_en) begin
      r_pix_cnt <= '0;
    end else begin
      r_pix_cnt <= r_pix_cnt + PIX_ONE;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_hc    <= '0;
      r_vc    <= '0;
      r_frame <= '0;
    end else if (w_pix_en) begin
      if (w_h_last) begin
        r_hc <= '0;
        if (w_v_last) begin
          r_vc    <= '0;
          r_frame <= (r_frame == F_LAST) ? '0 : r_frame + F_ONE;
        end else begin
          r_vc <= r_vc + 10'd1;
        end
      end else begin
        r_hc <= r_hc + 10'd1;
      end
    end
  end

  // Sampled only at the start of bottom blanking so a frame never tears.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_dx <= DX_RST;
      r_dy <= DY_RST;
    end else if (w_pix_en && w_h_last && (r_vc == VC_LATCH)) begin
      r_dx <= dot_x;
      r_dy <= dot_y;
    end
  end

  assign w_active = (r_hc >= HBP) && (r_hc < HFP) && (r_vc >= VBP) && (r_vc < VFP);
  assign w_dx_end = {1'b0, r_dx} + {1'b0, DOT_SIZE};
  assign w_dy_end = {1'b0, r_dy} + {1'b0, DOT_SIZE};
  assign w_dot    = (r_hc >= r_dx) && ({1'b0, r_hc} < w_dx_end) &&
                    (r_vc >= r_dy) && ({1'b0, r_vc} < w_dy_end);

`ifdef PLAYFIELD_BORDER_EN
  logic w_border;
  assign w_border = (((r_hc == X_LO) || (r_hc == X_HI)) && (r_vc >= Y_LO) && (r_vc <= Y_HI)) ||
                    (((r_vc == Y_LO) || (r_vc == Y_HI)) && (r_hc >= X_LO) && (r_hc <= X_HI));
`endif

  always_comb begin
    w_color = BG_COLOR;
    if (!w_active) begin
      w_color = 8'h00;
    end else if (w_dot) begin
      w_color = DOT_COLOR;
    end
`ifdef PLAYFIELD_BORDER_EN
    else if (w_border) begin
      w_color = BORDER_COLOR;
    end
`endif
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_hsync <= 1'b1;
      r_vsync <= 1'b1;
      r_rgb   <= 8'h00;
    end else if (w_pix_en) begin
      r_hsync <= !(r_hc < HPULSE);
      r_vsync <= !(r_vc < VPULSE);
      r_rgb   <= w_color;
    end
  end

  // Rises one clk after the frame counter reaches its last value, i.e. at hc=vc=0.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_cursor      <= 1'b0;
      r_prev_cursor <= 1'b0;
    end else begin
      r_cursor      <= (r_frame == F_LAST);
      r_prev_cursor <= r_cursor;
    end
  end

  assign hsync           = r_hsync;
  assign vsync           = r_vsync;
  assign {red, green, blue} = r_rgb;
  assign clk_cursor      = r_cursor;
  assign prev_clk_cursor = r_prev_cursor;

endmodule

// File: tb/tb_vga_dot_render.sv
// Directed bench for vga_dot_render on a shrunken 40x30 raster so several frames fit in a short run.
// Border expectations follow PLAYFIELD_BORDER_EN.
module tb_vga_dot_render;

  localparam int PD = 4;
  localparam int HP = 40;
  localparam int VL = 30;
  localparam int NPIX = HP * VL;
  localparam int FRAME_CLK = PD * NPIX;
`ifdef PLAYFIELD_BORDER_EN
  localparam logic [7:0] EXP_BORDER = 8'h1C;
`else
  localparam logic [7:0] EXP_BORDER = 8'h00;
`endif

  typedef struct {
    int         f;
    int         h;
    int         v;
    logic [9:0] dx;
    logic [9:0] dy;
    logic [7:0] rgb;
    logic       hs;
    logic       vs;
  } vec_t;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic [9:0] dot_x = 10'd22;
  logic [9:0] dot_y = 10'd15;
  logic       hsync, vsync;
  logic [2:0] red, green;
  logic [1:0] blue;
  logic       clk_cursor, prev_clk_cursor;

  int n_checks = 0;
  int n_fail = 0;
  int edge_cnt = 0;
  vec_t vecs[$];

  vga_dot_render #(
    .PIX_DIV(4), .HPIXELS(10'd40), .VLINES(10'd30), .HPULSE(10'd4), .VPULSE(10'd2),
    .HBP(10'd8), .HFP(10'd36), .VBP(10'd3), .VFP(10'd27), .DOT_SIZE(10'd3), .CURSOR_DIV(2)
`ifdef PLAYFIELD_BORDER_EN
    , .X_LO(10'd10), .X_HI(10'd34), .Y_LO(10'd5), .Y_HI(10'd25)
`endif
  ) u_dut (
    .clk(clk), .clr(clr), .dot_x(dot_x), .dot_y(dot_y),
    .hsync(hsync), .vsync(vsync), .red(red), .green(green), .blue(blue),
    .clk_cursor(clk_cursor), .prev_clk_cursor(prev_clk_cursor)
  );

  // Clock and edge counter (edges since clr release)
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!clr) edge_cnt = 0;
    else edge_cnt = edge_cnt + 1;
  end

  // Sync edge monitor for the first frames after the first release
  logic mon_en = 1'b0;
  logic hs_q = 1'b1, vs_q = 1'b1;
  int hs_fall[2] = '{0, 0};
  int vs_fall[2] = '{0, 0};
  int hs_rise = 0, vs_rise = 0;
  int hs_nf = 0, vs_nf = 0, hs_nr = 0, vs_nr = 0;

  always @(negedge clk) begin
    if (mon_en && clr) begin
      if (hs_q && !hsync && hs_nf < 2) begin hs_fall[hs_nf] = edge_cnt; hs_nf++; end
      if (!hs_q && hsync && hs_nr == 0) begin hs_rise = edge_cnt; hs_nr++; end
      if (vs_q && !vsync && vs_nf < 2) begin vs_fall[vs_nf] = edge_cnt; vs_nf++; end
      if (!vs_q && vsync && vs_nr == 0) begin vs_rise = edge_cnt; vs_nr++; end
      hs_q = hsync;
      vs_q = vsync;
    end
  end

  // Driver / scoreboard tasks
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic goto_edge(input int n);
    if (edge_cnt > n) begin
      n_checks++;
      n_fail++;
      $display("FAIL goto_edge: already at edge %0d expected at most %0d", edge_cnt, n);
    end
    while (edge_cnt < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic goto_pixel(input int f, input int h, input int v);
    goto_edge(PD * (f * NPIX + v * HP + h + 1));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " hsync"}, 32'(hsync), 32'd1);
    check({tag, " vsync"}, 32'(vsync), 32'd1);
    check({tag, " rgb"}, 32'({red, green, blue}), 32'h00);
    check({tag, " clk_cursor"}, 32'(clk_cursor), 32'd0);
    check({tag, " prev_cursor"}, 32'(prev_clk_cursor), 32'd0);
  endtask

  initial begin
    // Frame 0: default dot (22..24,15..17); dot_x=12 applied at vc=10 must not show yet
    vecs.push_back('{0,  0,  0, 10'd22, 10'd15, 8'h00, 1'b0, 1'b0});
    vecs.push_back('{0, 10,  5, 10'd22, 10'd15, EXP_BORDER, 1'b1, 1'b1});
    vecs.push_back('{0,  5, 10, 10'd12, 10'd15, 8'h00, 1'b1, 1'b1});
    vecs.push_back('{0, 22, 14, 10'd12, 10'd15, 8'h00, 1'b1, 1'b1});
    vecs.push_back('{0, 21, 15, 10'd12, 10'd15, 8'h00, 1'b1, 1'b1});
    vecs.push_back('{0, 22, 15, 10'd12, 10'd15, 8'hE0, 1'b1, 1'b1});
    vecs.push_back('{0, 12, 16, 10'd12, 10'd15, 8'h00, 1'b1, 1'b1});
    vecs.push_back('{0, 24, 17, 10'd12, 10'd15, 8'hE0, 1'b1, 1'b1});
    vecs.push_back('{0, 25, 17, 10'd12, 10'd15, 8'h00, 1'b1, 1'b1});
    vecs.push_back('{0, 23, 18, 10'd12, 10'd15, 8'h00, 1'b1, 1'b1});
    // Frame 1: dot at (12..14,15..17); right-edge clip position requested for frame 2
    vecs.push_back('{1, 12, 15, 10'd12, 10'd15, 8'hE0, 1'b1, 1'b1});
    vecs.push_back('{1, 22, 15, 10'd12, 10'd15, 8'h00, 1'b1, 1'b1});
    vecs.push_back('{1, 11, 16, 10'd12, 10'd15, 8'h00, 1'b1, 1'b1});
    vecs.push_back('{1, 15, 16, 10'd12, 10'd15, 8'h00, 1'b1, 1'b1});
    vecs.push_back('{1, 14, 17, 10'd12, 10'd15, 8'hE0, 1'b1, 1'b1});
    vecs.push_back('{1,  2, 20, 10'd34, 10'd20, 8'h00, 1'b0, 1'b1});
    // Frame 2: dot at hc 34..36, hc 36 falls into blanking
    vecs.push_back('{2, 33, 20, 10'd34, 10'd20, 8'h00, 1'b1, 1'b1});
    vecs.push_back('{2, 34, 20, 10'd34, 10'd20, 8'hE0, 1'b1, 1'b1});
    vecs.push_back('{2, 36, 20, 10'd34, 10'd20, 8'h00, 1'b1, 1'b1});
    vecs.push_back('{2, 37, 21, 10'd34, 10'd20, 8'h00, 1'b1, 1'b1});
    vecs.push_back('{2, 35, 22, 10'd34, 10'd20, 8'hE0, 1'b1, 1'b1});
    vecs.push_back('{2,  0, 28, 10'd22, 10'd0,  8'h00, 1'b0, 1'b1});
    // Frame 3: dot_y=0 lies wholly in top blanking
    vecs.push_back('{3, 22,  1, 10'd22, 10'd0,  8'h00, 1'b1, 1'b0});
    vecs.push_back('{3, 22,  3, 10'd22, 10'd0,  8'h00, 1'b1, 1'b1});
    vecs.push_back('{3, 23, 15, 10'd22, 10'd0,  8'h00, 1'b1, 1'b1});

    // Initial reset
    #2 clr = 1'b0;
    #1 check_reset_outputs("reset");
    repeat (3) @(posedge clk);
    #1 clr = 1'b1;
    mon_en = 1'b1;

    goto_edge(3);
    check("edge3 hsync", 32'(hsync), 32'd1);
    goto_edge(4);
    check("edge4 hsync", 32'(hsync), 32'd0);
    check("edge4 vsync", 32'(vsync), 32'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      dot_x = vecs[i].dx;
      dot_y = vecs[i].dy;
      goto_pixel(vecs[i].f, vecs[i].h, vecs[i].v);
      check($sformatf("v%0d(%0d,%0d,%0d) rgb", i, vecs[i].f, vecs[i].h, vecs[i].v),
            32'({red, green, blue}), 32'(vecs[i].rgb));
      check($sformatf("v%0d hsync", i), 32'(hsync), 32'(vecs[i].hs));
      check($sformatf("v%0d vsync", i), 32'(vsync), 32'(vecs[i].vs));
    end

    mon_en = 1'b0;
    check("hsync period", 32'(hs_fall[1] - hs_fall[0]), 32'(PD * HP));
    check("hsync low", 32'(hs_rise - hs_fall[0]), 32'(PD * 4));
    check("vsync period", 32'(vs_fall[1] - vs_fall[0]), 32'(FRAME_CLK));
    check("vsync low", 32'(vs_rise - vs_fall[0]), 32'(PD * 2 * HP));

    // Cursor: high through frame 3, low through frame 4, high again from frame 5
    goto_edge(4 * FRAME_CLK);
    check("cur f4 edge", 32'(clk_cursor), 32'd1);
    goto_edge(4 * FRAME_CLK + 1);
    check("cur f4+1", 32'(clk_cursor), 32'd0);
    check("prev f4+1", 32'(prev_clk_cursor), 32'd1);
    goto_edge(4 * FRAME_CLK + 2);
    check("prev f4+2", 32'(prev_clk_cursor), 32'd0);
    dot_x = 10'd12;
    dot_y = 10'd15;
    goto_edge(5 * FRAME_CLK);
    check("cur f5 edge", 32'(clk_cursor), 32'd0);
    goto_edge(5 * FRAME_CLK + 1);
    check("cur f5+1", 32'(clk_cursor), 32'd1);
    check("prev f5+1", 32'(prev_clk_cursor), 32'd0);
    goto_edge(5 * FRAME_CLK + 2);
    check("prev f5+2", 32'(prev_clk_cursor), 32'd1);

    // Mid-frame reset while the dot is on screen and the cursor is high
    goto_pixel(5, 12, 15);
    check("f5 dot", 32'({red, green, blue}), 32'hE0);
    goto_pixel(5, 13, 15);
    check("pre-rst rgb", 32'({red, green, blue}), 32'hE0);
    check("pre-rst cursor", 32'(clk_cursor), 32'd1);
    clr = 1'b0;
    dot_x = 10'd30;
    dot_y = 10'd8;
    #1 check_reset_outputs("mid reset");
    repeat (3) @(posedge clk);
    #1 clr = 1'b1;

    goto_edge(3);
    check("rel edge3 hsync", 32'(hsync), 32'd1);
    goto_edge(4);
    check("rel edge4 hsync", 32'(hsync), 32'd0);
    check("rel edge4 vsync", 32'(vsync), 32'd0);
    goto_pixel(0, 30, 8);
    check("rel f0 (30,8)", 32'({red, green, blue}), 32'h00);
    goto_pixel(0, 22, 15);
    check("rel f0 default dot", 32'({red, green, blue}), 32'hE0);
    goto_pixel(1, 30, 8);
    check("rel f1 (30,8)", 32'({red, green, blue}), 32'hE0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
